// File: rtl/pipe_adder.sv
// pipe_adder: ready/valid adder/subtractor whose carry chain is split into one slice per pipeline stage.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic             SUB,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;
    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_params
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end
    logic              adv;
    logic              z_q;
    logic [STAGES-1:0] v_q, vi, c_q, ci, cn;
    logic [SLICE-1:0]  sn;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  ai  [STAGES];
    logic [WIDTH-1:0]  bi  [STAGES];
    logic [WIDTH-1:0]  ri  [STAGES];
    logic [WIDTH-1:0]  rn  [STAGES];
    // stage k adds slice k of the operands it received plus the carry from stage k-1
    always_comb begin
        vi = '0;
        ci = '0;
        cn = '0;
        sn = '0;
        ai[0] = IN1;
        bi[0] = SUB ? ~IN2 : IN2;
        ri[0] = '0;
        ci[0] = SUB | CIN;
        vi[0] = IN_VALID;
        for (int k = 1; k < STAGES; k++) begin
            ai[k] = a_q[k-1];
            bi[k] = b_q[k-1];
            ri[k] = r_q[k-1];
            ci[k] = c_q[k-1];
            vi[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            {cn[k], sn} = {1'b0, ai[k][k*SLICE +: SLICE]} + {1'b0, bi[k][k*SLICE +: SLICE]}
                        + {{SLICE{1'b0}}, ci[k]};
            rn[k] = ri[k];
            rn[k][k*SLICE +: SLICE] = sn;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            z_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (adv) begin
            v_q <= vi;
            c_q <= cn;
            z_q <= (rn[LAST] == '0);
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= ai[k];
                b_q[k] <= bi[k];
                r_q[k] <= rn[k];
            end
        end
    end
    assign adv       = !v_q[LAST] || OUT_READY;
    assign IN_READY  = adv;
    assign OUT_VALID = v_q[LAST];
    assign OUT       = r_q[LAST];
    assign COUT      = c_q[LAST];
    assign ZERO      = z_q;
    assign OVF       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) && (OUT[WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed vectors and stall/reset sequences on a 32/4 adder, plus random sweeps of 8/1, 16/2, 64/8.
module tb_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst, in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] in1, in2, out;
    int          n_cmp = 0;
    int          n_bad = 0;
    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic        sub;
        logic        cin;
        logic [31:0] out;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;
    vec_t tbl [12];
    pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN1(in1), .IN2(in2),
        .SUB(sub), .CIN(cin), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT(out),
        .COUT(cout), .OVF(ovf), .ZERO(zero)
    );
    task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 64;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        logic         s_rst, iv, ir, sb, ci, ov, orr, co, of, z;
        logic         done = 1'b0;
        logic [W-1:0] a, b, o;
        logic [W+2:0] q [$];
        pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .rst(s_rst), .IN_VALID(iv), .IN_READY(ir), .IN1(a), .IN2(b),
            .SUB(sb), .CIN(ci), .OUT_VALID(ov), .OUT_READY(orr), .OUT(o),
            .COUT(co), .OVF(of), .ZERO(z)
        );
        function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s, input logic c);
            logic [W-1:0] e;
            logic [W:0]   f;
            e = s ? ~y : y;
            f = {1'b0, x} + {1'b0, e} + {{W{1'b0}}, s | c};
            return {f[W-1:0], f[W], (x[W-1] == e[W-1]) && (f[W-1] != x[W-1]), f[W-1:0] == '0};
        endfunction
        initial begin
            logic [W+2:0] e;
            s_rst = 1'b1; iv = 1'b0; a = '0; b = '0; sb = 1'b0; ci = 1'b0; orr = 1'b1;
            repeat (2) @(negedge clk);
            s_rst = 1'b0;
            for (int t = 0; t < 400; t++) begin
                @(negedge clk);
                iv  = (t < 360) ? ($urandom_range(0, 3) != 0) : 1'b0;
                a   = W'({$urandom, $urandom});
                b   = W'({$urandom, $urandom});
                sb  = 1'($urandom_range(0, 1));
                ci  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) b = a;
                orr = (t < 360) ? ($urandom_range(0, 3) != 0) : 1'b1;
                #1;
                if (ov && orr) begin
                    if (q.size() == 0) chk($sformatf("sw%0d unexpected result", W), 1, 0);
                    else begin
                        e = q.pop_front();
                        chk($sformatf("sw%0d result {out,cout,ovf,zero}", W), {o, co, of, z}, e);
                    end
                end
                if (iv && ir) q.push_back(model(a, b, sb, ci));
            end
            chk($sformatf("sw%0d results lost", W), q.size(), 0);
            done = 1'b1;
        end
    end
    initial begin
        int lat, cnt;
        tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{32'h00000001, 32'h00000002, 1'b0, 1'b1, 32'h00000004, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32'h0000000A, 32'h0000000A, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset out", out, 0);
        chk("reset flags", {cout, ovf, zero}, 0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in1 = tbl[i].in1; in2 = tbl[i].in2; sub = tbl[i].sub; cin = tbl[i].cin; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("vec%0d latency", i), lat, 4);
            chk($sformatf("vec%0d out", i), out, tbl[i].out);
            chk($sformatf("vec%0d cout", i), cout, tbl[i].cout);
            chk($sformatf("vec%0d ovf", i), ovf, tbl[i].ovf);
            chk($sformatf("vec%0d zero", i), zero, tbl[i].zero);
        end
        @(negedge clk);
        sub = 1'b0; cin = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c >= 4 && c < 12) begin
                chk($sformatf("b2b valid c%0d", c), out_valid, 1);
                chk($sformatf("b2b out c%0d", c), out, 2 * (c - 3));
            end else chk($sformatf("b2b idle c%0d", c), out_valid, 0);
            in_valid = (c < 8); in1 = c + 1; in2 = c + 1;
            @(negedge clk);
        end
        in2 = '0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1; in1 = 21 + j;
            @(negedge clk);
        end
        out_ready = 1'b0; in1 = 99;
        #1;
        for (int j = 0; j < 6; j++) begin
            chk("bp in_ready", in_ready, 0);
            chk("bp out_valid", out_valid, 1);
            chk("bp out held", out, 21);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1; in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("bp drain valid %0d", j), out_valid, 1);
            chk($sformatf("bp drain out %0d", j), out, 21 + j);
            @(negedge clk);
        end
        chk("bp no duplicate", out_valid, 0);
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in1 = 50 + j;
            @(negedge clk);
        end
        rst = 1'b1; in1 = 77;
        #1;
        chk("rst in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("post-rst out_valid", out_valid, 0);
        chk("post-rst out", out, 0);
        chk("post-rst flags", {cout, ovf, zero}, 0);
        in_valid = 1'b1; in1 = 60; in2 = 5;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        for (int j = 0; j < 10; j++) begin
            if (out_valid) begin
                cnt++;
                chk("post-rst result", out, 65);
            end
            @(negedge clk);
        end
        chk("post-rst result count", cnt, 1);
        for (int t = 0; t < 5000 && !(sw[0].done && sw[1].done && sw[2].done); t++) @(negedge clk);
        chk("sweeps finished", {sw[0].done, sw[1].done, sw[2].done}, 3'b111);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth, one carry-chain slice per stage; WIDTH % STAGES == 0 is legal, any other value SHALL fail elaboration.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port IN_VALID  input  1  operand set present.
REQ-006 SHALL have port IN_READY  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports IN1, IN2  input  WIDTH  operands (two's complement or unsigned).
REQ-008 SHALL have port SUB  input  1  1 = IN1 - IN2, 0 = IN1 + IN2.
REQ-009 SHALL have port CIN  input  1  carry-in, add mode only.
REQ-010 SHALL have port OUT_VALID  output  1  result present.
REQ-011 SHALL have port OUT_READY  input  1  consumer accepts result.
REQ-012 SHALL have port OUT  output  WIDTH  sum/difference modulo 2^WIDTH.
REQ-013 SHALL have ports COUT, OVF, ZERO  output  1 each  carry-out, signed overflow, result == 0.

Function
REQ-014 SHALL accept an operand set on any clk edge where IN_VALID && IN_READY (input transfer).
REQ-015 SHALL complete an output transfer on any clk edge where OUT_VALID && OUT_READY.
REQ-016 SHALL compute, with SLICE = WIDTH/STAGES: stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] of IN1 and of the effective B, plus the carry from stage k-1; the unused operand slices and the partial result travel with the pipeline.
REQ-017 SHALL use effective B = ~IN2 and carry-in 1 when SUB=1 (CIN ignored); effective B = IN2 and carry-in CIN when SUB=0.
REQ-018 SHALL have latency exactly STAGES cycles from input transfer to OUT_VALID rising, absent stalls; STAGES=1 degenerates to a single registered adder.
REQ-019 SHALL sustain throughput of one operation per cycle while OUT_READY=1.
REQ-020 SHALL stall globally: advance = !OUT_VALID || OUT_READY; when advance=0 every stage register, valid bit, and output SHALL hold.
REQ-021 SHALL drive IN_READY = advance, combinationally, with no dependence on IN_VALID.
REQ-022 SHALL let bubbles (valid=0 stages) advance only when advance=1; no bubble collapsing is required.
REQ-023 SHALL hold OUT, COUT, OVF, ZERO stable while OUT_VALID=1 and OUT_READY=0.
REQ-024 SHALL set COUT to the carry out of bit WIDTH-1; in SUB mode COUT=1 means no borrow.
REQ-025 SHALL set OVF = (sign of A == sign of effective B) && (sign of OUT != sign of A).
REQ-026 SHALL set ZERO = (OUT == 0), registered with the final stage.
REQ-027 SHALL wrap modulo 2^WIDTH without saturation.
REQ-028 SHALL keep data, flag, and valid registers in the same stage in lockstep; results SHALL emerge in acceptance order.
REQ-029 SHALL treat the values of OUT, COUT, OVF, and ZERO as don't-care while OUT_VALID=0.

Reset
REQ-030 SHALL, on a clk edge with rst=1, clear all stage valid bits and clear OUT, COUT, OVF, and ZERO to 0; OUT_VALID SHALL be 0 from the following cycle.
REQ-031 SHALL, when rst is asserted mid-operation, discard all in-flight operations; no result accepted before reset SHALL appear after it.
REQ-032 SHALL drive IN_READY=1 during and after reset, since OUT_VALID=0; an input transfer on a reset edge SHALL be discarded.
REQ-033 SHALL treat rst as dominant over IN_VALID, OUT_READY, and advance on the same edge.

Verification
REQ-034 Bench SHALL check, at WIDTH=32 and STAGES=4, with OUT_READY=1: IN1=0xFFFFFFFF, IN2=0x00000001, SUB=0, CIN=0 -> after 4 cycles OUT=0x00000000, COUT=1, OVF=0, ZERO=1.
REQ-035 Bench SHALL check, for signed overflow: IN1=0x7FFFFFFF, IN2=0x00000001, SUB=0 -> OUT=0x80000000, OVF=1, COUT=0; and IN1=5, IN2=7, SUB=1 -> OUT=0xFFFFFFFE, COUT=0, OVF=0.
REQ-036 Bench SHALL check back-to-back operation: 8 consecutive transfers of IN1=i, IN2=i, i=1..8 -> OUT=2,4,...,16 on 8 consecutive cycles starting at cycle 4.
REQ-037 Bench SHALL check backpressure: hold OUT_READY=0 for 6 cycles with the pipeline full -> IN_READY=0, OUT held constant, no results lost or duplicated once OUT_READY returns to 1.
REQ-038 Bench SHALL check reset mid-stream: assert rst for 1 cycle with 3 operations in flight -> OUT_VALID=0 and all outputs 0 after reset, and only operations issued after reset emerge.
REQ-039 Bench SHALL check parameter sweep: WIDTH/STAGES of 8/1, 16/2, and 64/8 under random operands and random OUT_READY -> every result matches the reference arithmetic model, including COUT, OVF, and ZERO.
